// File: rtl/cfu_ram_pkg.sv
// Shared definitions for the CFU RAM access path.
// Holds the arbiter state encoding and the Wishbone field widths and
// fixed cycle-type values used on the cfu_ram_* master port.
package cfu_ram_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY,
        ARB_RESP
    } arb_state_t;

    localparam int WB_ADR_W = 30;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
    localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/cfu_ram_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   valid - one request bit per requester
//   ptr   - index with highest priority this round
//   any   - at least one requester is valid
//   index - lowest valid index at or after ptr, wrapping past NUM_REQ-1
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic               any,
    output logic [IDX_W-1:0]   index
);

    int               sum;
    logic [IDX_W-1:0] cand;

    // Walk the requesters starting at ptr; the first valid one found wins.
    always_comb begin
        any   = 1'b0;
        index = '0;
        sum   = 0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = int'(ptr) + k;
            if (sum >= NUM_REQ) begin
                sum = sum - NUM_REQ;
            end
            cand = IDX_W'(sum);
            if (!any && valid[cand]) begin
                any   = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/cfu_ram_arbiter.sv
// Round-robin arbiter sharing the CFU's single Wishbone RAM master port
// between NUM_REQ internal requesters. One classic single-beat cycle is
// issued at a time; completion, error and read data go back to the owner.
// Ports:
//   clk, reset            - clock; asynchronous active-high reset
//   req_valid/we/adr/     - per-requester request, held until req_done
//   wdata/sel
//   req_done, req_err     - one-cycle completion / error pulse to the owner
//   req_rdata             - data of the last completed read (shared)
//   cfu_ram_*             - Wishbone classic master port
//   busy                  - arbiter is not idle
module cfu_ram_arbiter
    import cfu_ram_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*30-1:0]     req_adr,
    input  logic [NUM_REQ*32-1:0]     req_wdata,
    input  logic [NUM_REQ*4-1:0]      req_sel,
    output logic [NUM_REQ-1:0]        req_done,
    output logic [NUM_REQ-1:0]        req_err,
    output logic [WB_DAT_W-1:0]       req_rdata,
    output logic [WB_ADR_W-1:0]       cfu_ram_adr,
    output logic [WB_DAT_W-1:0]       cfu_ram_dat_mosi,
    output logic [WB_SEL_W-1:0]       cfu_ram_sel,
    output logic                      cfu_ram_cyc,
    output logic                      cfu_ram_stb,
    output logic                      cfu_ram_we,
    output logic [2:0]                cfu_ram_cti,
    output logic [1:0]                cfu_ram_bte,
    input  logic [WB_DAT_W-1:0]       cfu_ram_dat_miso,
    input  logic                      cfu_ram_ack,
    input  logic                      cfu_ram_err,
    output logic                      busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    arb_state_t          state_q, state_d;
    logic [IDX_W-1:0]    grant_q, grant_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_pend_q, err_pend_d;
    logic                cyc_q, cyc_d;
    logic                we_q, we_d;
    logic [WB_ADR_W-1:0] adr_q, adr_d;
    logic [WB_DAT_W-1:0] dat_q, dat_d;
    logic [WB_SEL_W-1:0] sel_q, sel_d;
    logic [WB_DAT_W-1:0] rdata_q, rdata_d;

    logic                pick_any;
    logic [IDX_W-1:0]    pick_idx;
    logic                timeout_hit;
    logic [NUM_REQ-1:0]  grant_onehot;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .valid (req_valid),
        .ptr   (ptr_q),
        .any   (pick_any),
        .index (pick_idx)
    );

    // The counter holds the number of BUSY cycles already spent, so the
    // cycle in which it equals TIMEOUT-1 is the last one allowed.
    generate
        if (TIMEOUT == 0) begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end else begin : g_timeout
            assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
        end
    endgenerate

    // Next-state logic. A slave ack arriving in the final allowed BUSY
    // cycle still counts as a normal completion; only err or a silent
    // slave produce an error response.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        err_pend_d = err_pend_q;
        cyc_d      = cyc_q;
        we_d       = we_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        sel_d      = sel_q;
        rdata_d    = rdata_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    grant_d    = pick_idx;
                    adr_d      = req_adr[WB_ADR_W*int'(pick_idx) +: WB_ADR_W];
                    dat_d      = req_wdata[WB_DAT_W*int'(pick_idx) +: WB_DAT_W];
                    sel_d      = req_sel[WB_SEL_W*int'(pick_idx) +: WB_SEL_W];
                    we_d       = req_we[pick_idx];
                    cyc_d      = 1'b1;
                    cnt_d      = '0;
                    err_pend_d = 1'b0;
                    state_d    = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cfu_ram_err) begin
                    err_pend_d = 1'b1;
                    cyc_d      = 1'b0;
                    we_d       = 1'b0;
                    state_d    = ARB_RESP;
                end else if (cfu_ram_ack) begin
                    err_pend_d = 1'b0;
                    if (!we_q) begin
                        rdata_d = cfu_ram_dat_miso;
                    end
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = ARB_RESP;
                end else if (timeout_hit) begin
                    err_pend_d = 1'b1;
                    cyc_d      = 1'b0;
                    we_d       = 1'b0;
                    state_d    = ARB_RESP;
                end
            end
            ARB_RESP: begin
                ptr_d      = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
                cnt_d      = '0;
                err_pend_d = 1'b0;
                state_d    = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // All state, including the bus outputs, clears asynchronously so that
    // a reset mid-cycle drops cyc/stb without waiting for a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ARB_IDLE;
            grant_q    <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            err_pend_q <= 1'b0;
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            adr_q      <= '0;
            dat_q      <= '0;
            sel_q      <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            err_pend_q <= err_pend_d;
            cyc_q      <= cyc_d;
            we_q       <= we_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            sel_q      <= sel_d;
            rdata_q    <= rdata_d;
        end
    end

    assign grant_onehot     = NUM_REQ'(1) << grant_q;
    assign req_done         = (state_q == ARB_RESP) ? grant_onehot : '0;
    assign req_err          = (state_q == ARB_RESP && err_pend_q) ? grant_onehot : '0;
    assign req_rdata        = rdata_q;
    assign cfu_ram_adr      = adr_q;
    assign cfu_ram_dat_mosi = dat_q;
    assign cfu_ram_sel      = sel_q;
    assign cfu_ram_cyc      = cyc_q;
    assign cfu_ram_stb      = cyc_q;
    assign cfu_ram_we       = we_q;
    assign cfu_ram_cti      = WB_CTI_CLASSIC;
    assign cfu_ram_bte      = WB_BTE_LINEAR;
    assign busy             = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_cfu_ram_arbiter.sv
// Directed self-checking bench for cfu_ram_arbiter with two requesters and
// a short timeout of four BUSY cycles. The Wishbone slave is modelled by
// driving ack/err/dat_miso directly from the stimulus sequence.
module tb_cfu_ram_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_we;
    logic [59:0] req_adr;
    logic [63:0] req_wdata;
    logic [7:0]  req_sel;
    logic [1:0]  req_done;
    logic [1:0]  req_err;
    logic [31:0] req_rdata;
    logic [29:0] cfu_ram_adr;
    logic [31:0] cfu_ram_dat_mosi;
    logic [3:0]  cfu_ram_sel;
    logic        cfu_ram_cyc;
    logic        cfu_ram_stb;
    logic        cfu_ram_we;
    logic [2:0]  cfu_ram_cti;
    logic [1:0]  cfu_ram_bte;
    logic [31:0] cfu_ram_dat_miso;
    logic        cfu_ram_ack;
    logic        cfu_ram_err;
    logic        busy;

    int checks;
    int errors;

    cfu_ram_arbiter #(
        .NUM_REQ (2),
        .TIMEOUT (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_we           (req_we),
        .req_adr          (req_adr),
        .req_wdata        (req_wdata),
        .req_sel          (req_sel),
        .req_done         (req_done),
        .req_err          (req_err),
        .req_rdata        (req_rdata),
        .cfu_ram_adr      (cfu_ram_adr),
        .cfu_ram_dat_mosi (cfu_ram_dat_mosi),
        .cfu_ram_sel      (cfu_ram_sel),
        .cfu_ram_cyc      (cfu_ram_cyc),
        .cfu_ram_stb      (cfu_ram_stb),
        .cfu_ram_we       (cfu_ram_we),
        .cfu_ram_cti      (cfu_ram_cti),
        .cfu_ram_bte      (cfu_ram_bte),
        .cfu_ram_dat_miso (cfu_ram_dat_miso),
        .cfu_ram_ack      (cfu_ram_ack),
        .cfu_ram_err      (cfu_ram_err),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle request and slave controls.
    task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] we,
                                 input logic ack, input logic err,
                                 input logic [31:0] miso);
        req_valid        = valid;
        req_we           = we;
        cfu_ram_ack      = ack;
        cfu_ram_err      = err;
        cfu_ram_dat_miso = miso;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        req_adr   = '0;
        req_wdata = '0;
        req_sel   = '0;
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
        waitCycle();
        waitCycle();

        // Reset state
        checkOutput("rst_cyc", {31'b0, cfu_ram_cyc}, 32'd0);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_rdata", req_rdata, 32'h0);
        checkOutput("rst_done", {30'b0, req_done}, 32'd0);
        checkOutput("rst_cti_bte", {27'b0, cfu_ram_cti, cfu_ram_bte}, 32'd0);
        reset = 1'b0;

        // Single read from requester 0, ack after two wait states
        req_adr[29:0] = 30'h100;
        req_sel[3:0]  = 4'hF;
        applyStimulus(2'b01, 2'b00, 1'b0, 1'b0, 32'h0);
        waitCycle();
        checkOutput("rd_cyc1", {31'b0, cfu_ram_cyc}, 32'd1);
        checkOutput("rd_stb1", {31'b0, cfu_ram_stb}, 32'd1);
        checkOutput("rd_adr", {2'b0, cfu_ram_adr}, 32'h100);
        checkOutput("rd_we", {31'b0, cfu_ram_we}, 32'd0);
        checkOutput("rd_busy", {31'b0, busy}, 32'd1);
        waitCycle();
        checkOutput("rd_cyc2", {31'b0, cfu_ram_cyc}, 32'd1);
        waitCycle();
        checkOutput("rd_cyc3", {31'b0, cfu_ram_cyc}, 32'd1);
        applyStimulus(2'b01, 2'b00, 1'b1, 1'b0, 32'hDEADBEEF);
        waitCycle();
        checkOutput("rd_done", {30'b0, req_done}, 32'd1);
        checkOutput("rd_err", {30'b0, req_err}, 32'd0);
        checkOutput("rd_rdata", req_rdata, 32'hDEADBEEF);
        checkOutput("rd_cyc_drop", {31'b0, cfu_ram_cyc}, 32'd0);
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
        waitCycle();
        checkOutput("rd_done_clr", {30'b0, req_done}, 32'd0);
        checkOutput("rd_idle", {31'b0, busy}, 32'd0);

        // Write from requester 1
        req_adr[59:30]   = 30'h200;
        req_wdata[63:32] = 32'h0000ABCD;
        req_sel[7:4]     = 4'b0011;
        applyStimulus(2'b10, 2'b10, 1'b0, 1'b0, 32'h55555555);
        waitCycle();
        checkOutput("wr_cyc", {31'b0, cfu_ram_cyc}, 32'd1);
        checkOutput("wr_we", {31'b0, cfu_ram_we}, 32'd1);
        checkOutput("wr_adr", {2'b0, cfu_ram_adr}, 32'h200);
        checkOutput("wr_dat", cfu_ram_dat_mosi, 32'h0000ABCD);
        checkOutput("wr_sel", {28'b0, cfu_ram_sel}, 32'h3);
        applyStimulus(2'b10, 2'b10, 1'b1, 1'b0, 32'h55555555);
        waitCycle();
        checkOutput("wr_done", {30'b0, req_done}, 32'd2);
        checkOutput("wr_rdata_keep", req_rdata, 32'hDEADBEEF);
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
        waitCycle();

        // Both requesters continuously valid, zero-wait ack: 0,1,0
        req_adr[29:0]  = 30'h10;
        req_adr[59:30] = 30'h20;
        applyStimulus(2'b11, 2'b00, 1'b1, 1'b0, 32'hA0A0A0A0);
        waitCycle();
        checkOutput("rr_g0_adr", {2'b0, cfu_ram_adr}, 32'h10);
        waitCycle();
        checkOutput("rr_g0_done", {30'b0, req_done}, 32'd1);
        checkOutput("rr_g0_rdata", req_rdata, 32'hA0A0A0A0);
        waitCycle();
        checkOutput("rr_gap_cyc", {31'b0, cfu_ram_cyc}, 32'd0);
        checkOutput("rr_gap_done", {30'b0, req_done}, 32'd0);
        waitCycle();
        checkOutput("rr_g1_adr", {2'b0, cfu_ram_adr}, 32'h20);
        applyStimulus(2'b11, 2'b00, 1'b1, 1'b0, 32'hB1B1B1B1);
        waitCycle();
        checkOutput("rr_g1_done", {30'b0, req_done}, 32'd2);
        checkOutput("rr_g1_rdata", req_rdata, 32'hB1B1B1B1);
        applyStimulus(2'b11, 2'b00, 1'b1, 1'b0, 32'hC2C2C2C2);
        waitCycle();
        waitCycle();
        checkOutput("rr_g2_adr", {2'b0, cfu_ram_adr}, 32'h10);
        waitCycle();
        checkOutput("rr_g2_done", {30'b0, req_done}, 32'd1);
        checkOutput("rr_g2_rdata", req_rdata, 32'hC2C2C2C2);
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
        waitCycle();

        // Slave error (with ack) on first BUSY cycle, requester 1
        req_adr[59:30] = 30'h30;
        applyStimulus(2'b10, 2'b00, 1'b0, 1'b0, 32'h0);
        waitCycle();
        checkOutput("er_adr", {2'b0, cfu_ram_adr}, 32'h30);
        applyStimulus(2'b10, 2'b00, 1'b1, 1'b1, 32'hFFFFFFFF);
        waitCycle();
        checkOutput("er_done", {30'b0, req_done}, 32'd2);
        checkOutput("er_err", {30'b0, req_err}, 32'd2);
        checkOutput("er_rdata_keep", req_rdata, 32'hC2C2C2C2);
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
        waitCycle();

        // Following request completes normally
        req_adr[29:0] = 30'h40;
        applyStimulus(2'b01, 2'b00, 1'b1, 1'b0, 32'h12345678);
        waitCycle();
        checkOutput("af_adr", {2'b0, cfu_ram_adr}, 32'h40);
        waitCycle();
        checkOutput("af_done", {30'b0, req_done}, 32'd1);
        checkOutput("af_err", {30'b0, req_err}, 32'd0);
        checkOutput("af_rdata", req_rdata, 32'h12345678);
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
        waitCycle();

        // Silent slave: timeout after four BUSY cycles
        applyStimulus(2'b10, 2'b00, 1'b0, 1'b0, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            waitCycle();
            checkOutput($sformatf("to_cyc%0d", i), {31'b0, cfu_ram_cyc}, 32'd1);
        end
        waitCycle();
        checkOutput("to_cyc_drop", {31'b0, cfu_ram_cyc}, 32'd0);
        checkOutput("to_done", {30'b0, req_done}, 32'd2);
        checkOutput("to_err", {30'b0, req_err}, 32'd2);
        checkOutput("to_rdata_keep", req_rdata, 32'h12345678);
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
        waitCycle();
        checkOutput("to_busy_clr", {31'b0, busy}, 32'd0);

        // Move the pointer to 1, then reset in the middle of a grant to 1
        req_adr[29:0]  = 30'h50;
        req_adr[59:30] = 30'h60;
        applyStimulus(2'b01, 2'b00, 1'b1, 1'b0, 32'h0);
        waitCycle();
        waitCycle();
        applyStimulus(2'b11, 2'b00, 1'b0, 1'b0, 32'h0);
        waitCycle();
        waitCycle();
        checkOutput("rs_pre_adr", {2'b0, cfu_ram_adr}, 32'h60);
        checkOutput("rs_pre_cyc", {31'b0, cfu_ram_cyc}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("rs_cyc_async", {31'b0, cfu_ram_cyc}, 32'd0);
        checkOutput("rs_stb_async", {31'b0, cfu_ram_stb}, 32'd0);
        checkOutput("rs_busy_async", {31'b0, busy}, 32'd0);
        checkOutput("rs_done_async", {30'b0, req_done}, 32'd0);
        waitCycle();
        checkOutput("rs_done_hold", {30'b0, req_done}, 32'd0);
        waitCycle();
        reset = 1'b0;
        applyStimulus(2'b11, 2'b00, 1'b1, 1'b0, 32'h0);
        waitCycle();
        checkOutput("rs_first_adr", {2'b0, cfu_ram_adr}, 32'h50);
        waitCycle();
        checkOutput("rs_first_done", {30'b0, req_done}, 32'd1);
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
        waitCycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cfu_ram_arbiter.md
Name: cfu_ram_arbiter

Overview:
- Round-robin arbiter that shares the CFU's single Wishbone RAM master port (cfu_ram_*) between NUM_REQ internal requesters, e.g. operand fetch, filter fetch and result writeback.
- Issues one classic single-beat Wishbone cycle at a time, on behalf of the granted requester, and returns read data, completion and error to that requester.
- Sits between the CFU sequencing logic and the top-level cfu_ram_* pins; replaces direct per-requester bus driving.

Parameters:
- NUM_REQ, 2, number of requesters, range 2..8.
- TIMEOUT, 255, BUSY cycles without ack/err before forced error termination; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  reset, asynchronous, active-high.
- req_valid  in  NUM_REQ  per-requester request; held with its fields until that requester's req_done.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_adr  in  NUM_REQ*30  word address, requester i at [30*i+:30].
- req_wdata  in  NUM_REQ*32  write data, requester i at [32*i+:32].
- req_sel  in  NUM_REQ*4  byte enables, requester i at [4*i+:4].
- req_done  out  NUM_REQ  one-cycle completion pulse to the owning requester.
- req_err  out  NUM_REQ  one-cycle error pulse, coincident with req_done.
- req_rdata  out  32  read data of the last completed read, shared by all requesters.
- cfu_ram_adr  out  30  Wishbone address.
- cfu_ram_dat_mosi  out  32  Wishbone write data.
- cfu_ram_sel  out  4  Wishbone byte select.
- cfu_ram_cyc  out  1  Wishbone cycle.
- cfu_ram_stb  out  1  Wishbone strobe.
- cfu_ram_we  out  1  Wishbone write enable.
- cfu_ram_cti  out  3  tied to 3'b000 (classic cycle).
- cfu_ram_bte  out  2  tied to 2'b00 (linear).
- cfu_ram_dat_miso  in  32  Wishbone read data.
- cfu_ram_ack  in  1  Wishbone acknowledge.
- cfu_ram_err  in  1  Wishbone error.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset values:
  - state IDLE, rr pointer 0, timeout counter 0.
  - cyc/stb/we 0, adr/dat_mosi/sel 0.
  - req_done 0, req_err 0, req_rdata 0, busy 0.
- Reset is asynchronous and may occur mid-cycle: cyc/stb drop immediately, no done or err pulse is issued, and the requester must re-request.
- States:
  - IDLE: if any req_valid, pick the winner starting at the rr pointer (lowest index at or after the pointer, wrapping), latch its grant index and its adr/wdata/sel/we into the bus output registers, set cyc=stb=1, and go to BUSY.
  - BUSY: cyc/stb held high and bus outputs stable; the timeout counter increments each cycle.
    - ack=1: capture dat_miso into req_rdata if read; drop cyc/stb/we; go to RESP with done pending.
    - err=1 (with or without ack): leave req_rdata unchanged; go to RESP with err pending. err has priority over ack.
    - Counter reaches TIMEOUT (when TIMEOUT != 0): treat as err.
  - RESP: req_done[g]=1 (and req_err[g] if err pending) for exactly one cycle; rr pointer <= (g+1) mod NUM_REQ; counter cleared; go to IDLE. No arbitration in RESP, so a requester can drop req_valid the cycle it sees done.
- Latency with zero-wait ack (ack in the first BUSY cycle):
  - req_valid at cycle 0 -> cyc at cycle 1 -> req_done at cycle 2.
  - Next grant earliest at cycle 3.
- Fairness: with all NUM_REQ requesting continuously, each is served exactly once per NUM_REQ transactions.
- req_valid dropped by the granted requester while in BUSY: the cycle still completes and done is still pulsed (a Wishbone cycle cannot be aborted).
- Changes on the fields of a non-granted requester are ignored until it is granted.
- ack or err while in IDLE or RESP: ignored.

Decomposition:
- Package cfu_ram_pkg:
  - arb_state_t enum {ARB_IDLE, ARB_BUSY, ARB_RESP}.
  - Constants WB_ADR_W=30, WB_DAT_W=32, WB_SEL_W=4, WB_CTI_CLASSIC=3'b000, WB_BTE_LINEAR=2'b00.
- One sub-module, rr_pick: combinational round-robin picker, inputs valid vector and pointer, outputs any and index.

Test Plan:
- Single read, requester 0: adr=30'h100, slave ack after 2 wait states with dat_miso=32'hDEADBEEF -> cyc high 3 cycles, req_done[0] pulses once, req_rdata=32'hDEADBEEF, req_err=0.
- Write, requester 1: we=1, sel=4'b0011, wdata=32'h0000ABCD -> bus carries those values with we=1 while cyc is high, req_done[1] pulses, req_rdata unchanged.
- Both requesters valid continuously, zero-wait ack -> grants alternate 0,1,0,1; each transaction takes 3 cycles; no back-to-back grant to the same requester.
- Slave asserts err on the 1st BUSY cycle -> req_done and req_err pulse together, req_rdata unchanged, next request proceeds normally.
- TIMEOUT=4, slave never acks -> cyc drops after 4 BUSY cycles, req_err pulses, busy returns to 0.
- Reset asserted mid-BUSY -> cyc/stb go to 0 asynchronously, no req_done pulse, pointer 0, and requester 0 wins first after release when both request.
